ysyx_23060208_isram_slave: RTL



---
 rtl/ysyx_23060208_isram_slave_pkg.sv | 18 +
 rtl/ysyx_23060208_lfsr8.sv | 31 +++
 rtl/ysyx_23060208_isram_slave.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_isram_slave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ysyx_23060208_isram_slave_pkg                              |
// | Description : Shared response codes, ISRAM base and FSM state encodings  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package ysyx_23060208_isram_slave_pkg;

    localparam logic [1:0]  RRESP_OKAY   = 2'b00;
    localparam logic [1:0]  RRESP_SLVERR = 2'b10;
    localparam logic [31:0] ISRAM_BASE   = 32'h8000_0000;

    localparam logic [1:0]  IDLE  = 2'b00;
    localparam logic [1:0]  DELAY = 2'b01;
    localparam logic [1:0]  RESP  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060208_lfsr8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ysyx_23060208_lfsr8                                        |
// | Description : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free running      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ysyx_23060208_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

    assign out = r_state;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060208_isram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ysyx_23060208_isram_slave                                  |
// | Description : Instruction SRAM AR/R read slave with variable latency     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module ysyx_23060208_isram_slave
    import ysyx_23060208_isram_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4096,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter bit                    RANDOM_LAT = 1'b1,
    parameter int unsigned           FIXED_LAT  = 2,
    parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [1:0]            rresp,
    input  logic                  rready,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic [7:0]            w_lfsr;
    logic                  w_lfsr_unused;
    logic [2:0]            w_lat;
    logic                  w_ar_fire;
    logic                  w_enter_resp;

    logic [DATA_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_off;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_ld_off;
    logic                  w_ld_ok;

    ysyx_23060208_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (w_lfsr)
    );

    assign w_lfsr_unused = &{1'b0, w_lfsr[7:3]};
    assign w_lat         = RANDOM_LAT ? w_lfsr[2:0] : 3'(FIXED_LAT);
    assign w_ar_fire     = arvalid && arready;
    assign w_enter_resp  = (w_ar_fire && (w_lat == 3'd0)) ||
                           ((r_state == DELAY) && (r_cnt == 3'd1));

    // A zero-latency request is decoded straight from the bus, otherwise from the latched address
    assign w_rd_addr = (r_state == IDLE) ? araddr : r_addr;
    assign w_rd_off  = w_rd_addr - BASE_ADDR;
    assign w_rd_ok   = (w_rd_addr >= BASE_ADDR) && (w_rd_off[1:0] == 2'b00) &&
                       ({2'b00, w_rd_off[DATA_WIDTH-1:2]} < DATA_WIDTH'(DEPTH));

    assign w_ld_off  = load_addr - BASE_ADDR;
    assign w_ld_ok   = (load_addr >= BASE_ADDR) && (w_ld_off[1:0] == 2'b00) &&
                       ({2'b00, w_ld_off[DATA_WIDTH-1:2]} < DATA_WIDTH'(DEPTH));

    always_ff @(posedge clk) begin
        if (load_en && w_ld_ok) begin
            r_mem[w_ld_off[c_IDX_W+1:2]] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_ar_fire) w_next_state = (w_lat != 3'd0) ? DELAY : RESP;
            DELAY:   if (r_cnt == 3'd1) w_next_state = RESP;
            RESP:    if (rready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state == IDLE);
        rvalid  = (r_state == RESP);
    end

    // Non-blocking sampling of r_mem gives read-before-write against a same-edge load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_rdata <= '0;
            r_rresp <= RRESP_OKAY;
        end else begin
            if (w_ar_fire) begin
                r_addr <= araddr;
                r_cnt  <= w_lat;
            end else if (r_state == DELAY) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rd_ok ? r_mem[w_rd_off[c_IDX_W+1:2]] : '0;
                r_rresp <= w_rd_ok ? RRESP_OKAY : RRESP_SLVERR;
            end
        end
    end

    assign rdata = r_rdata;
    assign rresp = r_rresp;

endmodule
`default_nettype wire
